fpu_acc_seq: RTL

//  Streaming block accumulator wrapped around a combinational fpu_add instance (upstream and downstream of it).

---
 rtl/fpu_acc_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fpu_acc_seq.sv
// fpu_acc_seq: streaming block accumulator wrapped around a combinational fpu_add.
// It accepts LEN samples over valid/ready and drives add_a = running sum and add_b = sample.
// It registers add_result back into the running sum.
// It emits the block total with a one-cycle sum_valid pulse.
// Optional feature macro: FPU_ACC_PIPE_EN.
//   Defined: the sample is registered into b_q and the add completes in a WAIT state.
//   This gives 1 sample per 2 cycles and cuts the in_data -> fpu_add -> acc path.
module fpu_acc_seq #(
   parameter bit double = 1'b0,
   parameter int LEN_W  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [LEN_W-1:0]                len,
   input  logic [(double ? 64 : 32)-1:0]   in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [(double ? 64 : 32)-1:0]   add_a,
   output logic [(double ? 64 : 32)-1:0]   add_b,
   input  logic [(double ? 64 : 32)-1:0]   add_result,
   input  logic                            add_exception,
   output logic [(double ? 64 : 32)-1:0]   sum,
   output logic                            sum_valid,
   output logic                            busy,
   output logic                            exc_flag
);

   localparam int W = double ? 64 : 32;

`ifdef FPU_ACC_PIPE_EN
   typedef enum logic [1:0] {IDLE, ACCUM, WAIT, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
`endif

   state_t           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     sum_q, sum_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             exc_q, exc_d;
`ifdef FPU_ACC_PIPE_EN
   logic [W-1:0]     b_q, b_d;
   logic             last_q, last_d;
`endif

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         exc_q   <= 1'b0;
`ifdef FPU_ACC_PIPE_EN
         b_q     <= '0;
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         exc_q   <= exc_d;
`ifdef FPU_ACC_PIPE_EN
         b_q     <= b_d;
         last_q  <= last_d;
`endif
      end
   end

   // next-state, datapath updates and handshake/status outputs
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      exc_d     = exc_q;
`ifdef FPU_ACC_PIPE_EN
      b_d       = b_q;
      last_d    = last_q;
`endif
      in_ready  = 1'b0;
      add_a     = acc_q;
      add_b     = '0;
      sum_valid = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (start) begin
               exc_d = 1'b0;
               if (len != '0) begin
                  acc_d   = '0;
                  cnt_d   = len;
                  state_d = ACCUM;
               end else begin
                  // an empty block still reports a +0.0 total
                  sum_d   = '0;
                  state_d = DONE;
               end
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            add_b    = in_data;
            if (in_valid) begin
               // cnt is always >= 1 here, so the decrement cannot wrap
               cnt_d = cnt_q - LEN_W'(1);
`ifdef FPU_ACC_PIPE_EN
               b_d     = in_data;
               last_d  = (cnt_q == LEN_W'(1));
               state_d = WAIT;
`else
               acc_d = add_result;
               exc_d = exc_q | add_exception;
               if (cnt_q == LEN_W'(1)) begin
                  sum_d   = add_result;
                  state_d = DONE;
               end
`endif
            end
         end
`ifdef FPU_ACC_PIPE_EN
         WAIT: begin
            add_b = b_q;
            acc_d = add_result;
            exc_d = exc_q | add_exception;
            if (last_q) begin
               sum_d   = add_result;
               state_d = DONE;
            end else begin
               state_d = ACCUM;
            end
         end
`endif
         DONE: begin
            // a start seen here is dropped; acceptance needs state IDLE
            sum_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sum      = sum_q;
   assign exc_flag = exc_q;

endmodule
